// File: rtl/i2s_tx.sv
`default_nettype none
// =============================================================================
// Module   : i2s_tx
// Purpose  : Stereo PCM serialiser (I2S, or left-justified when the macro
//            I2S_TX_LEFT_JUSTIFIED_EN is defined), stepped by BCLK fall strobes.
// Revision : 1.0
// =============================================================================
module i2s_tx #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int SLOT_BITS    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    bclk_rise,
   input  logic                    bclk_fall,
   input  logic                    en,
   input  logic [SAMPLE_WIDTH-1:0] left_data,
   input  logic [SAMPLE_WIDTH-1:0] right_data,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic                    sdata,
   output logic                    lrclk,
   output logic                    underrun,
   output logic                    busy
);

   localparam int            FW     = 2 * SLOT_BITS;
   localparam int            CW     = $clog2(FW);
   localparam logic [CW-1:0] C_LAST = CW'(FW - 1);
   localparam logic [CW-1:0] C_SLOT = CW'(SLOT_BITS);

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
   localparam logic C_LEFT_LVL  = 1'b1;
   localparam logic C_RIGHT_LVL = 1'b0;
`else
   localparam logic C_LEFT_LVL  = 1'b0;
   localparam logic C_RIGHT_LVL = 1'b1;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  state_q;
   logic [CW-1:0]           bit_cnt_q;
   logic [FW-1:0]           frame_q;
   logic [SAMPLE_WIDTH-1:0] hold_l_q;
   logic [SAMPLE_WIDTH-1:0] hold_r_q;
   logic                    hold_full_q;
   logic                    sdata_q;
   logic                    lrclk_q;
   logic                    underrun_q;

   logic                    w_active;
   logic                    w_wrap;
   logic                    w_take;
   logic                    w_start;
   logic                    w_stop;
   logic                    w_step;
   logic [CW-1:0]           w_cnt_inc;
   logic [FW-1:0]           w_frame_new;
   logic [FW-1:0]           w_load;
   logic                    w_start_bit;
   logic                    w_stop_bit;

   function automatic logic [FW-1:0] pack_frame(input logic [SAMPLE_WIDTH-1:0] l,
                                                input logic [SAMPLE_WIDTH-1:0] r);
      logic [FW-1:0] f;
      f = '0;
      f[FW-1 -: SAMPLE_WIDTH]        = l;
      f[SLOT_BITS-1 -: SAMPLE_WIDTH] = r;
      return f;
   endfunction

   assign w_active    = (state_q != S_IDLE);
   assign w_wrap      = (bit_cnt_q == C_LAST);
   assign w_take      = sample_valid && !hold_full_q;
   assign w_cnt_inc   = bit_cnt_q + CW'(1);
   assign w_frame_new = hold_full_q ? pack_frame(hold_l_q, hold_r_q) : '0;

   // A frame starts out of IDLE (only with a pair waiting) or on a wrap while enabled
   assign w_start = bclk_fall && ((!w_active && en && hold_full_q) || (w_active && w_wrap && en));
   assign w_stop  = bclk_fall && w_active && w_wrap && !en;
   assign w_step  = bclk_fall && w_active && !w_wrap;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
   assign w_start_bit = w_frame_new[FW-1];
   assign w_load      = w_frame_new << 1;
   assign w_stop_bit  = 1'b0;
`else
   // One-BCLK delay: the previous frame's last bit goes out at count 0
   assign w_start_bit = frame_q[FW-1];
   assign w_load      = w_frame_new;
   assign w_stop_bit  = frame_q[FW-1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         frame_q     <= '0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         hold_full_q <= 1'b0;
         sdata_q     <= 1'b0;
         lrclk_q     <= C_RIGHT_LVL;
         underrun_q  <= 1'b0;
      end else begin
         underrun_q <= 1'b0;

         // An empty buffer at frame start still accepts a same-cycle pair for the next frame
         if (w_take) begin
            hold_l_q    <= left_data;
            hold_r_q    <= right_data;
            hold_full_q <= 1'b1;
         end else if (w_start) begin
            hold_full_q <= 1'b0;
         end

         if (w_start) begin
            bit_cnt_q  <= '0;
            lrclk_q    <= C_LEFT_LVL;
            sdata_q    <= w_start_bit;
            frame_q    <= w_load;
            underrun_q <= ~hold_full_q;
         end else if (w_stop) begin
            bit_cnt_q <= '0;
            lrclk_q   <= C_RIGHT_LVL;
            sdata_q   <= w_stop_bit;
            frame_q   <= '0;
         end else if (w_step) begin
            bit_cnt_q <= w_cnt_inc;
            lrclk_q   <= (w_cnt_inc < C_SLOT) ? C_LEFT_LVL : C_RIGHT_LVL;
            sdata_q   <= frame_q[FW-1];
            frame_q   <= frame_q << 1;
         end else if (bclk_fall) begin
            sdata_q <= 1'b0;
         end

         if (w_start) begin
            state_q <= S_RUN;
         end else if (w_stop) begin
            state_q <= S_IDLE;
         end else if (w_active) begin
            state_q <= en ? S_RUN : S_DRAIN;
         end
      end
   end

   assign sample_ready = ~hold_full_q;
   assign sdata        = sdata_q;
   assign lrclk        = lrclk_q;
   assign underrun     = underrun_q;
   assign busy         = w_active;

   a_strobe_excl : assert property (@(posedge clk) disable iff (rst) !(bclk_rise && bclk_fall));

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// =============================================================================
// Module   : tb_i2s_tx
// Purpose  : Scoreboard bench for i2s_tx; serial frames are decoded back into
//            sample pairs and matched against handshaken pairs.
// Revision : 1.0
// =============================================================================
module tb_i2s_tx;

   localparam int SW   = 24;
   localparam int SLOT = 32;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
   localparam bit   LJ      = 1'b1;
   localparam logic C_LEFT  = 1'b1;
   localparam logic C_RIGHT = 1'b0;
`else
   localparam bit   LJ      = 1'b0;
   localparam logic C_LEFT  = 1'b0;
   localparam logic C_RIGHT = 1'b1;
`endif

   logic          clk, rst, bclk_rise, bclk_fall, en, sample_valid;
   logic [SW-1:0] left_data, right_data;
   logic          sample_ready, sdata, lrclk, underrun, busy;

   i2s_tx #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT)) dut (
      .clk(clk), .rst(rst), .bclk_rise(bclk_rise), .bclk_fall(bclk_fall), .en(en),
      .left_data(left_data), .right_data(right_data), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .sdata(sdata), .lrclk(lrclk), .underrun(underrun),
      .busy(busy)
   );

   typedef struct {
      logic [SW-1:0] l;
      logic [SW-1:0] r;
      int            e;
   } pair_t;

   pair_t       exp_q[$];
   logic [47:0] got_q[$];
   int          checks = 0, errors = 0;
   int          edge_n = 0;

   int          k = 0, mon_p = 0, frames_started = 0, frames_done = 0, uruns = 0;
   bit          open = 1'b0, fall_prev = 1'b0;
   logic        lr_last = C_RIGHT;
   logic [63:0] bits = '0;
   pair_t       cur;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_n = edge_n + 1;

   // BCLK divider /8: rise at phase 0, fall at phase 4
   initial begin
      int div;
      div = 0;
      bclk_rise = 1'b0;
      bclk_fall = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         div = (div + 1) % 8;
         bclk_rise = (div == 0);
         bclk_fall = (div == 4);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic finalize();
      chk("left_slot", bits[63:40], cur.l);
      chk("right_slot", bits[31:8], cur.r);
      chk("pad_bits", {bits[39:32], bits[7:0]}, 0);
      got_q.push_back({bits[63:40], bits[31:8]});
      frames_done++;
      open = 1'b0;
   endtask

   // Monitor: outputs at a negedge reflect the edge that sampled fall_prev
   always @(negedge clk) begin
      bit start, consumed;
      int p;
      if (rst) begin
         open = 1'b0; k = 0; mon_p = 0; lr_last = C_RIGHT; fall_prev = 1'b0;
      end else begin
         if (underrun) uruns++;
         if (fall_prev) begin
            start = (lrclk == C_LEFT) && (lr_last == C_RIGHT);
            if (start) begin
               if (!LJ) begin
                  if (open) begin
                     chk("frame_len", k, 63);
                     bits[0] = sdata;
                     finalize();
                  end else begin
                     chk("first_bit_after_idle", sdata, 0);
                  end
               end else begin
                  chk("frame_open_at_start", open, 0);
               end
               consumed = (exp_q.size() > 0) && (exp_q[0].e < edge_n);
               chk("underrun_at_start", underrun, !consumed);
               if (consumed) begin
                  cur = exp_q.pop_front();
                  chk("ready_after_start", sample_ready, 1);
               end else begin
                  cur.l = '0; cur.r = '0; cur.e = 0;
               end
               open = 1'b1; k = 0; mon_p = 0; frames_started++;
               if (LJ) begin
                  bits[63] = sdata;
                  k = 1;
               end
            end else begin
               chk("underrun_mid", underrun, 0);
               if (open) begin
                  mon_p++;
                  p = LJ ? k : k + 1;
                  if (p < 64) chk("lrclk_slot", lrclk, (p < SLOT) ? C_LEFT : C_RIGHT);
                  bits[63-k] = sdata;
                  k++;
                  if (k == 64) finalize();
               end else begin
                  chk("idle_sdata", sdata, 0);
                  chk("idle_lrclk", lrclk, C_RIGHT);
               end
            end
         end else begin
            chk("underrun_quiet", underrun, 0);
         end
         lr_last = lrclk;
         fall_prev = bclk_fall;
      end
   end

   function automatic bit cond(input int what, input int val);
      case (what)
         0:       return frames_started >= val;
         1:       return frames_done >= val;
         2:       return mon_p == val;
         3:       return exp_q.size() == 0;
         default: return busy == 1'b0;
      endcase
   endfunction

   task automatic wait_until(input int what, input int val, input int lim, input string nm);
      bit ok;
      int i;
      ok = cond(what, val);
      i = 0;
      while (!ok && i < lim) begin
         @(posedge clk);
         #2;
         ok = cond(what, val);
         i++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: condition not reached in %0d cycles", nm, lim);
      end
   endtask

   task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r, input bit last);
      bit done;
      int i;
      done = 1'b0;
      i = 0;
      left_data = l;
      right_data = r;
      sample_valid = 1'b1;
      while (!done && i < 1500) begin
         @(negedge clk);
         if (sample_ready) begin
            exp_q.push_back('{l, r, edge_n + 1});
            done = 1'b1;
         end
         i++;
         @(posedge clk);
         #2;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout_handshake: ready never seen, got 0 expected 1");
         sample_valid = 1'b0;
      end
      if (last) sample_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, sample_ready, 1);
      chk({tag, "_sdata"}, sdata, 0);
      chk({tag, "_lrclk"}, lrclk, C_RIGHT);
      chk({tag, "_underrun"}, underrun, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      logic [SW-1:0] ml, mr, bl, br, fl, fr;
      int done_at_reset;
      rst = 1'b1; en = 1'b0; sample_valid = 1'b0; left_data = '0; right_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Single pair, then an underrun frame, then a pair supplied mid-frame
      en = 1'b1;
      send_pair(24'hA5F03C, 24'h5AC3F0, 1'b1);
      wait_until(0, 2, 2000, "frame2_start");
      wait_until(2, int'($urandom_range(5, 50)), 600, "frame2_mid");
      ml = SW'($urandom); mr = SW'($urandom);
      send_pair(ml, mr, 1'b1);

      // Back-to-back source with incrementing values
      bl = SW'($urandom); br = SW'($urandom);
      for (int i = 0; i < 8; i++) send_pair(bl + SW'(i), br + SW'(i), i == 7);
      wait_until(3, 0, 1500, "last_pair_consumed");
      wait_until(2, 10, 600, "drain_point");
      en = 1'b0;
      wait_until(4, 0, 1500, "drain_idle");
      repeat (40) @(posedge clk);
      #2;
      chk("drain_busy", busy, 0);
      chk("drain_lrclk_idle", lrclk, C_RIGHT);
      chk("drain_sdata_idle", sdata, 0);
      chk("drain_frames_complete", frames_done, frames_started);
      chk("frame_count", got_q.size(), 11);
      if (got_q.size() >= 11) begin
         chk("frame1_pair", got_q[0], {24'hA5F03C, 24'h5AC3F0});
         chk("frame2_zero", got_q[1], 0);
         chk("frame3_pair", got_q[2], {ml, mr});
         chk("frame11_pair", got_q[10], {bl + SW'(7), br + SW'(7)});
      end
      chk("underrun_total", uruns, 1);

      // Asynchronous reset in the middle of a frame
      en = 1'b1;
      send_pair(SW'($urandom), SW'($urandom), 1'b1);
      wait_until(3, 0, 1500, "pre_reset_consumed");
      send_pair(SW'($urandom), SW'($urandom), 1'b1);
      wait_until(2, 40, 600, "reset_point");
      done_at_reset = frames_done;
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      exp_q.delete();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      fl = SW'($urandom); fr = SW'($urandom);
      send_pair(fl, fr, 1'b1);
      wait_until(3, 0, 1500, "post_reset_consumed");
      wait_until(2, 10, 600, "post_reset_drain_point");
      en = 1'b0;
      wait_until(4, 0, 1500, "post_reset_idle");
      repeat (40) @(posedge clk);
      #2;
      chk("post_reset_frames", frames_done, done_at_reset + 1);
      if (got_q.size() > 0) chk("post_reset_pair", got_q[got_q.size()-1], {fl, fr});
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serialises stereo PCM sample pairs onto an I2S (or left-justified) data line.
- Driven by the single-cycle bit-clock edge strobes of the upstream clock divider; runs entirely in the system clk domain.
- Sample pairs arrive from the mixer core over a valid/ready handshake into a one-deep holding buffer.
- Sits between the mixer datapath and the DAC pins (sdata, lrclk; BCLK pin driven directly by the divider output).

Parameters:
- SAMPLE_WIDTH, 24, bits per channel sample (two's complement, MSB first).
- SLOT_BITS, 32, BCLK periods per channel slot; must be >= SAMPLE_WIDTH. Frame = 2*SLOT_BITS BCLKs.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- bclk_rise  input  1  one-clk strobe, BCLK rising edge (from divider)
- bclk_fall  input  1  one-clk strobe, BCLK falling edge (from divider)
- en  input  1  transmit enable
- left_data  input  SAMPLE_WIDTH  left sample
- right_data  input  SAMPLE_WIDTH  right sample
- sample_valid  input  1  pair presented
- sample_ready  output  1  holding buffer empty
- sdata  output  1  serial data to DAC
- lrclk  output  1  word select
- underrun  output  1  one-clk pulse, frame started with no sample
- busy  output  1  high in RUN or DRAIN

Behaviour:
- Interface: clock clk; reset rst, asynchronous, active-high.
- Reset: sdata=0, lrclk=RIGHT_LVL, sample_ready=1, underrun=0, busy=0, bit_cnt=0, holding empty, state IDLE.
- Levels: LEFT_LVL=0, RIGHT_LVL=1 (I2S).
- Only bclk_fall advances state; bclk_rise is unused except in the optional feature. Both strobes high in the same cycle is illegal; assert.
- Handshake: transfer when sample_valid && sample_ready. Latch {left,right} into holding; sample_ready drops the next cycle. sample_ready = holding empty.
- Counter: bit_cnt runs 0..2*SLOT_BITS-1, incremented on each bclk_fall in RUN/DRAIN, wrapping to 0. A "frame start" is a bclk_fall at which bit_cnt wraps to 0 (or the first bclk_fall out of IDLE).
- Frame load (at frame start):
  - Frame word F = {left, zeros(SLOT_BITS-SAMPLE_WIDTH), right, zeros(...)} taken from holding; holding is emptied.
  - If holding is empty, F = all zeros and underrun pulses for one clk in the same cycle.
  - A handshake in the same cycle as frame start lands in holding for the next frame; the current frame still underruns.
- Output timing: all sdata/lrclk updates occur in the cycle after bclk_fall (registered).
  - lrclk = LEFT_LVL for bit_cnt < SLOT_BITS, else RIGHT_LVL.
  - sdata at count p = F[2*SLOT_BITS-1-((p-1) mod 2*SLOT_BITS)]. This is I2S one-BCLK delay; at p=0 sdata carries the last bit of the previous frame (0 after IDLE).
- State machine:
  - IDLE: bit_cnt held at 0; sdata=0; lrclk=RIGHT_LVL. Go to RUN at the first bclk_fall with en=1 and holding full; that edge is a frame start.
  - RUN: go to DRAIN when en=0 is sampled at any clk.
  - DRAIN: continue to end of frame. At the bclk_fall where bit_cnt would wrap, emit the delayed final bit at p=0, then go to IDLE. Holding contents are retained.
  - en re-asserted in DRAIN: return to RUN with no frame disruption.
- Reset mid-frame: immediate return to reset values; the partial frame is abandoned.

Optional Feature:
- Macro: I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format.
  - LEFT_LVL=1, RIGHT_LVL=0.
  - No one-bit delay: sdata at count p = F[2*SLOT_BITS-1-p].
  - Reset/idle lrclk=0.
- Undefined: standard I2S as above.

Test Plan:
- Single pair, I2S: SAMPLE_WIDTH=24, SLOT_BITS=32, L=24'hA5F03C, R=24'h5AC3F0, en=1, divider /8.
  - lrclk low for 32 BCLKs then high for 32 BCLKs.
  - sdata bits 1..24 after the lrclk fall = A5F03C MSB first, bits 25..32 = 0.
  - Right slot likewise carries 5AC3F0.
  - underrun=0.
- Back-to-back: the source keeps sample_valid high with incrementing values.
  - Exactly one handshake per frame; sample_ready re-rises one clk after each frame start.
  - No underrun over 8 frames.
- Underrun: no second pair supplied.
  - Frame 2 sdata all zero; underrun pulses exactly one clk at the frame-2 start.
  - A pair supplied mid-frame 2 appears in frame 3.
- Drain: deassert en at bit_cnt=10.
  - Frame completes through count 63 plus the delayed bit.
  - busy falls after that; lrclk idles high and sdata idles 0.
- Async reset at bit_cnt=40: outputs return to reset values without waiting for clk.
  - Next frame after release begins at bit_cnt=0 with a fresh handshake.
- With I2S_TX_LEFT_JUSTIFIED_EN: same stimulus as the first scenario.
  - lrclk high for the left slot.
  - A5F03C MSB appears at count 0 with no delay.
